// File: rtl/golden_nonce_uart_tx.sv
// Golden-nonce reporter: buffers found nonces in a small FIFO and sends each one to the
// host as little-endian 8N1 bytes. Define NONCE_TX_CHECKSUM_EN to append an XOR checksum byte.
module golden_nonce_uart_tx #(
  parameter int BAUD_DIV        = 868,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic        hash_clk,
  input  logic        reset,
  input  logic        golden_nonce_valid,
  input  logic [31:0] golden_nonce,
  output logic        uart_tx,
  output logic        busy,
  output logic        overflow
);

  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

`ifdef NONCE_TX_CHECKSUM_EN
  localparam int NBYTES = 5;
`else
  localparam int NBYTES = 4;
`endif

  localparam int SR_W = 8 * NBYTES;
  localparam logic [2:0] LAST_BYTE = 3'(NBYTES - 1);

  localparam int AW    = FIFO_DEPTH_LOG2;
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t          state;
  logic [BW-1:0]   baud_cnt;
  logic [2:0]      bit_cnt;
  logic [2:0]      byte_idx;
  logic [SR_W-1:0] shift_reg;

  logic [31:0]     fifo_mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     fifo_cnt;
  logic            fifo_push;
  logic            fifo_pop;
  logic [31:0]     head;
  logic [SR_W-1:0] load_word;
  logic            baud_wrap;

  assign head      = fifo_mem[rd_ptr];
  assign fifo_pop  = (state == IDLE) && (fifo_cnt != '0);
  // A pop on the same edge frees the slot, so a push into a full FIFO is still accepted.
  assign fifo_push = golden_nonce_valid && ((fifo_cnt != FULL_CNT) || fifo_pop);
  assign baud_wrap = (baud_cnt == BAUD_LAST);
  assign busy      = (state != IDLE) || (fifo_cnt != '0);

`ifdef NONCE_TX_CHECKSUM_EN
  assign load_word = {head[31:24] ^ head[23:16] ^ head[15:8] ^ head[7:0], head};
`else
  assign load_word = head;
`endif

  // NOTE: the storage array is deliberately not reset; pointers and count define its contents.
  always_ff @(posedge hash_clk) begin
    if (fifo_push) begin
      fifo_mem[wr_ptr] <= golden_nonce;
    end
  end

  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (fifo_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (fifo_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (golden_nonce_valid && !fifo_push) begin
        overflow <= 1'b1;
      end
    end
  end

  // The shift register moves right one place per data bit, so after 8 bits the
  // next byte of the frame is already sitting at the bottom.
  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      byte_idx  <= '0;
      shift_reg <= '0;
      uart_tx   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (fifo_cnt != '0) begin
            shift_reg <= load_word;
            byte_idx  <= '0;
            bit_cnt   <= '0;
            baud_cnt  <= '0;
            uart_tx   <= 1'b0;
            state     <= START;
          end
        end

        START: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            uart_tx  <= shift_reg[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        DATA: begin
          if (baud_wrap) begin
            baud_cnt  <= '0;
            shift_reg <= shift_reg >> 1;
            if (bit_cnt == 3'd7) begin
              bit_cnt <= '0;
              uart_tx <= 1'b1;
              state   <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              uart_tx <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        STOP: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            if (byte_idx != LAST_BYTE) begin
              byte_idx <= byte_idx + 1'b1;
              uart_tx  <= 1'b0;
              state    <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_golden_nonce_uart_tx.sv
// Bench for golden_nonce_uart_tx: a line monitor decodes 8N1 bytes and compares them
// against a byte scoreboard filled when each strobe is driven.
`timescale 1ns/1ps
module tb_golden_nonce_uart_tx;

  localparam int BAUD = 4;
`ifdef NONCE_TX_CHECKSUM_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif
  localparam int BYTE_CYC = 10 * BAUD;
  localparam int FRAME    = BYTE_CYC * NB;

  logic        hash_clk = 1'b0;
  logic        reset = 1'b1;
  logic        golden_nonce_valid = 1'b0;
  logic [31:0] golden_nonce = 32'h0;
  logic        uart_tx;
  logic        busy;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  int start_q[$];

  golden_nonce_uart_tx #(
    .BAUD_DIV(BAUD),
    .FIFO_DEPTH_LOG2(2)
  ) dut (
    .hash_clk(hash_clk),
    .reset(reset),
    .golden_nonce_valid(golden_nonce_valid),
    .golden_nonce(golden_nonce),
    .uart_tx(uart_tx),
    .busy(busy),
    .overflow(overflow)
  );

  always #5 hash_clk = ~hash_clk;
  always @(posedge hash_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic sb_push(input logic [31:0] v);
    for (int i = 0; i < 4; i++) exp_q.push_back(v[8*i +: 8]);
`ifdef NONCE_TX_CHECKSUM_EN
    exp_q.push_back(v[7:0] ^ v[15:8] ^ v[23:16] ^ v[31:24]);
`endif
  endtask

  // Called at a negedge; returns the cycle number of the edge that samples the strobe.
  task automatic strobe(input logic [31:0] v, input bit expect_sent, output int edge_cyc);
    golden_nonce       = v;
    golden_nonce_valid = 1'b1;
    if (expect_sent) sb_push(v);
    @(negedge hash_clk);
    edge_cyc = cyc;
  endtask

  task automatic strobe_done();
    golden_nonce_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < budget) begin
      @(negedge hash_clk);
      n++;
    end
    repeat (4) @(negedge hash_clk);
    check("drain_busy", 32'(busy), 0);
    check("drain_scoreboard", exp_q.size(), 0);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge hash_clk);
  endtask

  // Line monitor: finds each start bit, samples mid-bit, aborts a byte if reset hits.
  initial begin : monitor
    logic       prev;
    logic       ok;
    logic [9:0] bits;
    logic [7:0] exp_b;
    prev = 1'b1;
    forever begin
      @(negedge hash_clk);
      if (!reset && prev && !uart_tx) begin
        start_q.push_back(cyc);
        ok   = 1'b1;
        bits = '0;
        for (int k = 0; k < 10 && ok; k++) begin
          for (int w = 0; w < ((k == 0) ? 2 : 4); w++) begin
            @(negedge hash_clk);
            if (reset) ok = 1'b0;
          end
          bits[k] = uart_tx;
        end
        if (ok) begin
          check("start_bit", 32'(bits[0]), 0);
          check("stop_bit", 32'(bits[9]), 1);
          check("byte_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            exp_b = exp_q.pop_front();
            check("byte_value", 32'(bits[8:1]), 32'(exp_b));
          end
        end
      end
      prev = uart_tx;
    end
  end

  initial begin : main
    int e;
    int e2;
    int n;

    // Reset and 100 quiet cycles.
    repeat (3) @(negedge hash_clk);
    check("rst_uart_tx", 32'(uart_tx), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_overflow", 32'(overflow), 0);
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge hash_clk);
      if (i % 20 == 0) begin
        check("idle_uart_tx", 32'(uart_tx), 1);
        check("idle_busy", 32'(busy), 0);
        check("idle_overflow", 32'(overflow), 0);
      end
    end
    check("idle_no_start", start_q.size(), 0);

    // Single nonce: latency, byte order, frame length.
    strobe(32'h12345678, 1'b1, e);
    strobe_done();
    wait_until(e + FRAME);
    check("busy_last_stop_cycle", 32'(busy), 1);
    @(negedge hash_clk);
    check("line_high_after_frame", 32'(uart_tx), 1);
    check("busy_low_after_frame", 32'(busy), 0);
    check("single_byte_count", start_q.size(), NB);
    if (start_q.size() == NB) begin
      check("single_start_latency", start_q[0], e + 1);
      for (int i = 1; i < NB; i++) check("byte_spacing", start_q[i] - start_q[i-1], BYTE_CYC);
    end
    wait_drain(100);

    // Two nonces back to back: one idle cycle between frames.
    start_q.delete();
    strobe(32'hDEADBEEF, 1'b1, e);
    strobe(32'h00000001, 1'b1, e2);
    strobe_done();
    wait_drain(2 * FRAME + 100);
    check("pair_byte_count", start_q.size(), 2 * NB);
    if (start_q.size() == 2 * NB) begin
      check("pair_first_start", start_q[0], e + 1);
      check("pair_gap", start_q[NB] - start_q[NB-1], BYTE_CYC + 1);
      check("pair_second_start", start_q[NB], e + FRAME + 2);
    end

    // Six strobes into a 4-deep FIFO: the sixth is dropped.
    start_q.delete();
    for (int i = 1; i <= 6; i++) begin
      strobe(32'(i), i <= 5, e);
      check("overflow_flag", 32'(overflow), 32'(i == 6));
    end
    strobe_done();
    wait_drain(6 * FRAME + 100);
    check("overflow_sticky", 32'(overflow), 1);
    check("burst_byte_count", start_q.size(), 5 * NB);

    // Reset during DATA of byte 1: line high at once, nothing resumes.
    start_q.delete();
    strobe(32'hCAFEBABE, 1'b0, e);
    exp_q.push_back(8'hBE);
    strobe_done();
    wait_until(e + 1 + BYTE_CYC + BAUD + 12);
    check("mid_frame_bytes_started", start_q.size(), 2);
    check("mid_frame_busy", 32'(busy), 1);
    #1 reset = 1'b1;
    #1;
    check("reset_uart_tx_immediate", 32'(uart_tx), 1);
    check("reset_busy_immediate", 32'(busy), 0);
    check("reset_overflow_clear", 32'(overflow), 0);
    @(negedge hash_clk);
    @(negedge hash_clk);
    reset = 1'b0;
    n = start_q.size();
    repeat (200) @(negedge hash_clk);
    check("no_resume_start", start_q.size(), n);
    check("post_reset_busy", 32'(busy), 0);
    check("post_reset_uart_tx", 32'(uart_tx), 1);
    check("post_reset_scoreboard", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/golden_nonce_uart_tx.md
# golden_nonce_uart_tx

Reporting path for found shares. Accepts golden-nonce strobes from the miner control unit, buffers them in a small FIFO, and serialises each nonce to the host as a 4-byte 8N1 UART frame. It is the FPGA-to-host transmit end of the host link; work loading is the host-to-FPGA direction. Runs entirely in the `hash_clk` domain.

## Interface

Parameters:
- `BAUD_DIV`, default 868: `hash_clk` cycles per UART bit. Minimum 2. Width of the baud counter is `$clog2(BAUD_DIV)`.
- `FIFO_DEPTH_LOG2`, default 2: FIFO depth is 2^N entries of 32 bits.

Ports:
- `hash_clk`, in, 1: the single clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `golden_nonce_valid`, in, 1: single-cycle strobe; the nonce is present this cycle.
- `golden_nonce`, in, 32: nonce value, sampled when `golden_nonce_valid`=1.
- `uart_tx`, out, 1: serial line. Idle is high.
- `busy`, out, 1: 1 when the FSM is not in IDLE or the FIFO is non-empty.
- `overflow`, out, 1: sticky flag. Set when a strobe is dropped; cleared only by `reset`.

## Operation

- Reset values (applied asynchronously):
  - `uart_tx`=1, `busy`=0, `overflow`=0.
  - FIFO is emptied; FSM goes to IDLE; baud, bit and byte counters are 0.
- FIFO push:
  - Occurs on each edge where `golden_nonce_valid`=1.
  - If the FIFO is full and no pop happens on the same edge, the nonce is dropped and `overflow` is set.
  - A simultaneous push and pop while full is accepted: the pop frees the slot.
- FSM states are IDLE, START, DATA and STOP.
  - IDLE: if the FIFO is non-empty, pop the head into a 32-bit shift register, set byte index to 0, go to START. Otherwise stay.
  - START: drive `uart_tx`=0 for `BAUD_DIV` cycles, then go to DATA.
  - DATA: drive 8 bits, LSB first, each for `BAUD_DIV` cycles, then go to STOP.
  - STOP: drive `uart_tx`=1 for `BAUD_DIV` cycles.
    - If the byte index is less than 3: increment it, shift the next byte in, go to START. There are no idle bits between bytes.
    - If the byte index is 3: go to IDLE.
- Byte order is little-endian: `golden_nonce[7:0]` is sent first and `[31:24]` last.
- The baud counter counts 0 to `BAUD_DIV`-1. Bit boundaries occur on wrap. The counter is reset to 0 on every state entry from IDLE.
- A FIFO pointer wraps modulo 2^`FIFO_DEPTH_LOG2`. The occupancy count is `FIFO_DEPTH_LOG2`+1 bits wide.

## Timing

- Push edge E: `uart_tx` falls at edge E+1, provided the FSM is idle and the FIFO was empty.
- Frame length is 40·`BAUD_DIV` cycles, or 50·`BAUD_DIV` when `NONCE_TX_CHECKSUM_EN` is defined.
- Between frames: after the last stop bit the FSM spends exactly 1 cycle in IDLE. The next start bit begins on the following edge if the FIFO is non-empty.
- `uart_tx` is a registered output and is glitch-free.
- A reset asserted mid-frame forces `uart_tx` high immediately. No partial frame resumes after reset is released.

## Configuration

- `NONCE_TX_CHECKSUM_EN`
  - Defined: each frame carries a 5th byte equal to the XOR of the 4 nonce bytes, sent after byte 3 with the same start/stop framing. The byte index runs 0 to 4.
  - Undefined: frames are 4 bytes and no checksum logic is built.

## Test plan

All scenarios use `BAUD_DIV`=4 and `FIFO_DEPTH_LOG2`=2.

- Reset, no stimulus: `uart_tx`=1, `busy`=0 and `overflow`=0 for 100 cycles.
- Single strobe of 0x12345678 at edge E:
  - `uart_tx` falls at E+1.
  - Decoded bytes are 0x78, 0x56, 0x34, 0x12.
  - Line is high and `busy`=0 after edge E+161.
- With `NONCE_TX_CHECKSUM_EN` defined, the same 0x12345678 strobe produces 5 bytes; the 5th is 0x08, and the frame is 200 cycles.
- Two strobes on consecutive cycles, 0xDEADBEEF then 0x00000001: both frames are decoded in order, with exactly 1 high idle cycle between the first stop bit and the second start bit.
- Six strobes on consecutive cycles, values 1 through 6:
  - Nonces 1 to 5 are transmitted in order.
  - Nonce 6 is dropped.
  - `overflow`=1 from the 6th push edge onward.
- Reset pulsed during the DATA state of byte 1 of 0xCAFEBABE:
  - `uart_tx`=1 immediately.
  - After release, no further falling edge occurs and `busy`=0.
